// File: rtl/nrzi_stuff_tx.sv
// USB-style serial transmit encoder: SYNC generation, NRZI line coding, bit stuffing
// after runs of ones and an SE0/J end-of-packet, all sequenced from a single start pulse.
module nrzi_stuff_tx #(
    parameter int unsigned STUFF_LEN  = 6,
    parameter int unsigned SYNC_BITS  = 8,
    parameter int unsigned EOP_SE0    = 2,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic s_in,
    input  logic s_valid,
    input  logic s_last,
    output logic s_ready,
    output logic nrzi_out,
    output logic oe,
    output logic se0,
    output logic busy,
    output logic done,
    output logic underrun
);

    localparam int unsigned ONES_W  = $clog2(STUFF_LEN + 1);
    localparam int unsigned CNT_MAX = (SYNC_BITS > EOP_SE0) ? SYNC_BITS : EOP_SE0;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LEN);
    localparam logic [CNT_W-1:0]  SYNC_END = CNT_W'(SYNC_BITS - 1);
    localparam logic [CNT_W-1:0]  SE0_END  = CNT_W'(EOP_SE0 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_STUFF,
        S_EOP_SE0,
        S_EOP_J
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [ONES_W-1:0]  ones, ones_n, ones_inc;
    logic               last_pend, last_n;
    logic               nrzi_n, oe_n, se0_n, busy_n, done_n, underrun_n;
    logic               emit, bit_val;

    // Saturating increment keeps the run length from ever exceeding STUFF_LEN.
    assign ones_inc = (ones >= ONES_MAX) ? ONES_MAX : ones + ONES_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the comb blocks below use blocking ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ones      <= '0;
            last_pend <= 1'b0;
            nrzi_out  <= IDLE_LEVEL;
            oe        <= 1'b0;
            se0       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ones      <= ones_n;
            last_pend <= last_n;
            nrzi_out  <= nrzi_n;
            oe        <= oe_n;
            se0       <= se0_n;
            busy      <= busy_n;
            done      <= done_n;
            underrun  <= underrun_n;
        end
    end

    // NOTE: every comb output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last_pend;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_SYNC;
                    cnt_n   = '0;
                end
            end
            S_SYNC: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == SYNC_END) state_n = S_DATA;
            end
            S_DATA: begin
                if (!s_valid) begin
                    state_n = S_EOP_SE0;
                    cnt_n   = '0;
                end else if (s_in && (ones_inc == ONES_MAX)) begin
                    state_n = S_STUFF;
                    last_n  = s_last;
                end else if (s_last) begin
                    state_n = S_EOP_SE0;
                    cnt_n   = '0;
                end
            end
            S_STUFF: begin
                state_n = last_pend ? S_EOP_SE0 : S_DATA;
                cnt_n   = '0;
            end
            S_EOP_SE0: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == SE0_END) state_n = S_EOP_J;
            end
            S_EOP_J: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        s_ready    = 1'b0;
        emit       = 1'b0;
        bit_val    = 1'b0;
        nrzi_n     = nrzi_out;
        oe_n       = 1'b1;
        se0_n      = 1'b0;
        ones_n     = ones;
        done_n     = 1'b0;
        underrun_n = 1'b0;
        unique case (state)
            S_IDLE: begin
                oe_n   = 1'b0;
                nrzi_n = IDLE_LEVEL;
                if (start) ones_n = '0;
            end
            S_SYNC: begin
                emit    = 1'b1;
                bit_val = (cnt == SYNC_END);
            end
            S_DATA: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    emit    = 1'b1;
                    bit_val = s_in;
                end else begin
                    underrun_n = 1'b1;
                end
            end
            S_STUFF: emit = 1'b1;
            S_EOP_SE0: begin
                se0_n  = 1'b1;
                nrzi_n = 1'b0;
            end
            S_EOP_J: begin
                nrzi_n = IDLE_LEVEL;
                done_n = 1'b1;
            end
            default: oe_n = 1'b0;
        endcase
        // NRZI: a zero toggles the line, a one holds it.
        if (emit) begin
            nrzi_n = bit_val ? nrzi_out : ~nrzi_out;
            ones_n = bit_val ? ones_inc : '0;
        end
        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_nrzi_stuff_tx.sv
// Directed bench for nrzi_stuff_tx: a per-cycle vector table for a plain packet plus
// logged packet runs on three parameterisations for stuffing, underrun and EOP corners.
module tb_nrzi_stuff_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, s_in, s_valid, s_last;
    logic [2:0] rdy_w, nrzi_w, oe_w, se0_w, busy_w, done_w, und_w;
    logic [1:0] sel;
    logic ready, nrzi, oe, se0, busy, done, und;

    nrzi_stuff_tx #(.STUFF_LEN(6), .SYNC_BITS(8), .EOP_SE0(2), .IDLE_LEVEL(1'b1)) u_def (
        .clk(clk), .rst_n(rst_n), .start(start), .s_in(s_in), .s_valid(s_valid),
        .s_last(s_last), .s_ready(rdy_w[0]), .nrzi_out(nrzi_w[0]), .oe(oe_w[0]),
        .se0(se0_w[0]), .busy(busy_w[0]), .done(done_w[0]), .underrun(und_w[0]));

    nrzi_stuff_tx #(.STUFF_LEN(3), .SYNC_BITS(8), .EOP_SE0(2), .IDLE_LEVEL(1'b1)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start), .s_in(s_in), .s_valid(s_valid),
        .s_last(s_last), .s_ready(rdy_w[1]), .nrzi_out(nrzi_w[1]), .oe(oe_w[1]),
        .se0(se0_w[1]), .busy(busy_w[1]), .done(done_w[1]), .underrun(und_w[1]));

    nrzi_stuff_tx #(.STUFF_LEN(6), .SYNC_BITS(4), .EOP_SE0(4), .IDLE_LEVEL(1'b1)) u_e4 (
        .clk(clk), .rst_n(rst_n), .start(start), .s_in(s_in), .s_valid(s_valid),
        .s_last(s_last), .s_ready(rdy_w[2]), .nrzi_out(nrzi_w[2]), .oe(oe_w[2]),
        .se0(se0_w[2]), .busy(busy_w[2]), .done(done_w[2]), .underrun(und_w[2]));

    always_comb begin
        ready = rdy_w[sel];
        nrzi  = nrzi_w[sel];
        oe    = oe_w[sel];
        se0   = se0_w[sel];
        busy  = busy_w[sel];
        done  = done_w[sel];
        und   = und_w[sel];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle record: inputs driven this cycle, outputs expected at its start.
    typedef struct {
        logic       st, vld, din, lst;
        logic [6:0] exp; // {nrzi, oe, se0, busy, done, ready, underrun}
    } vec_t;
    vec_t tbl[$];

    function automatic void push(input logic st, vld, din, lst,
                                 input logic e_nrzi, e_oe, e_se0, e_busy, e_done, e_rdy);
        vec_t v;
        v.st = st; v.vld = vld; v.din = din; v.lst = lst;
        v.exp = {e_nrzi, e_oe, e_se0, e_busy, e_done, e_rdy, 1'b0};
        tbl.push_back(v);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; s_in = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [63:0] lvl_v, oe_v, se0_v, rdy_v, done_v, und_v;
    int n_cyc;
    int first_se0, se0_cnt, done_idx, und_cnt, und_idx, n_lvl;
    logic [63:0] lvl_pk;

    // Runs one packet with handshake; cycle k is sampled at the k-th negedge, start at k=0.
    task automatic run_packet(input string name, input logic [15:0] bits, input int nbits,
                              input int drop_at, input bit restart);
        int idx;
        bit done_seen;
        idx = 0; done_seen = 1'b0; n_cyc = 0;
        lvl_v = '0; oe_v = '0; se0_v = '0; rdy_v = '0; done_v = '0; und_v = '0;
        for (int k = 0; k < 64 && !done_seen; k++) begin
            @(negedge clk);
            lvl_v[k] = nrzi; oe_v[k] = oe; se0_v[k] = se0;
            rdy_v[k] = ready; done_v[k] = done; und_v[k] = und;
            n_cyc = k + 1;
            if (done) done_seen = 1'b1;
            start = (k == 0) || (restart && ready && idx == 1);
            if (ready && idx < nbits && idx != drop_at) begin
                s_valid = 1'b1; s_in = bits[idx]; s_last = (idx == nbits - 1); idx++;
            end else begin
                s_valid = 1'b0; s_in = 1'b0; s_last = 1'b0;
            end
        end
        start = 1'b0; s_valid = 1'b0; s_in = 1'b0; s_last = 1'b0;
        check({name, " done reached"}, 64'(done_seen), 64'd1);
        first_se0 = -1; se0_cnt = 0; done_idx = -1; und_cnt = 0; und_idx = -1;
        n_lvl = 0; lvl_pk = '0;
        for (int k = 0; k < n_cyc; k++) begin
            if (se0_v[k]) begin
                se0_cnt++;
                if (first_se0 < 0) first_se0 = k;
            end
            if (done_v[k] && done_idx < 0) done_idx = k;
            if (und_v[k]) begin
                und_cnt++;
                und_idx = k;
            end
            if (oe_v[k] && !se0_v[k] && first_se0 < 0) begin
                lvl_pk[n_lvl] = lvl_v[k];
                n_lvl++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit bad;
        sel = 2'd0;

        // Default packet 0x00: SYNC, eight toggling zeros, 2 SE0, J + done.
        push(1,0,0,0, 1,0,0,0,0,0);
        push(0,0,0,0, 1,0,0,1,0,0);
        for (int i = 0; i < 7; i++) push(0,0,0,0, (i % 2 == 1),1,0,1,0,0);
        push(0,1,0,0, 0,1,0,1,0,1);
        for (int j = 0; j < 7; j++) push(0,1,0,(j == 6), (j % 2 == 0),1,0,1,0,1);
        push(0,0,0,0, 0,1,0,1,0,0);
        push(0,0,0,0, 0,1,1,1,0,0);
        push(0,0,0,0, 0,1,1,1,0,0);
        push(0,0,0,0, 1,1,0,0,1,0);
        push(0,0,0,0, 1,0,0,0,0,0);

        do_reset();
        check("reset state", {nrzi, oe, se0, busy, done, ready, und}, 7'b1000000);
        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            check($sformatf("vec%0d", k), {nrzi, oe, se0, busy, done, ready, und}, tbl[k].exp);
            start = tbl[k].st; s_valid = tbl[k].vld; s_in = tbl[k].din; s_last = tbl[k].lst;
        end

        // Reset in the middle of SYNC: back to idle immediately, no done afterwards.
        do_reset();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("midsync reset", {nrzi, oe, busy, done}, 4'b1000);
        bad = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done || oe || busy) bad = 1'b1;
        end
        check("midsync quiet", 64'(bad), 64'd0);

        // 0xFF: stuff after the fifth payload one, s_ready low only there.
        do_reset();
        run_packet("ff", 16'h00FF, 8, -1, 1'b0);
        check("ff level count", n_lvl, 17);
        check("ff levels", lvl_pk, 64'(17'b11110000000101010));
        check("ff ready", 64'(rdy_v[18:0]), 64'({10'b0111011111, 9'b0}));
        check("ff first se0", first_se0, 19);
        check("ff se0 cycles", se0_cnt, 2);
        check("ff done idx", done_idx, 21);
        check("ff underrun", und_cnt, 0);

        // STUFF_LEN=3, payload 1,1 last: mandatory stuff then EOP.
        sel = 2'd1;
        do_reset();
        run_packet("s3", 16'h0003, 2, -1, 1'b0);
        check("s3 level count", n_lvl, 11);
        check("s3 levels", lvl_pk, 64'(11'b10000101010));
        check("s3 ready", 64'(rdy_v[14:0]), 64'h0600);
        check("s3 first se0", first_se0, 13);
        check("s3 se0 cycles", se0_cnt, 2);
        check("s3 done idx", done_idx, 15);

        // s_valid dropped after three bits: underrun, then EOP at once.
        sel = 2'd0;
        do_reset();
        run_packet("und", 16'h0005, 8, 3, 1'b0);
        check("und count", und_cnt, 1);
        check("und idx", und_idx, 13);
        check("und levels", lvl_pk, 64'(12'b111000101010));
        check("und level count", n_lvl, 12);
        check("und first se0", first_se0, 14);
        check("und se0 cycles", se0_cnt, 2);
        check("und done idx", done_idx, 16);

        // SYNC_BITS=4, EOP_SE0=4, start re-pulsed in DATA.
        sel = 2'd2;
        do_reset();
        run_packet("e4", 16'h0002, 2, -1, 1'b1);
        check("e4 levels", lvl_pk, 64'(6'b110010));
        check("e4 level count", n_lvl, 6);
        check("e4 ready", 64'(rdy_v[7:0]), 64'h60);
        check("e4 first se0", first_se0, 8);
        check("e4 se0 cycles", se0_cnt, 4);
        check("e4 done idx", done_idx, 12);
        @(negedge clk);
        check("e4 idle after", {oe, busy, se0}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
